// File: rtl/asteroid_field.sv
// Asteroid slot state engine: per-frame motion with screen wrap, LFSR-driven
// edge spawning, direct slot loads and kills, packed buses for the renderer.
module asteroid_field #(
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter int          SPAWN_PERIOD = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn_enable,
  input  logic        kill_valid,
  input  logic [2:0]  kill_index,
  input  logic        load_valid,
  input  logic [2:0]  load_index,
  input  logic [7:0]  load_x,
  input  logic [6:0]  load_y,
  input  logic [1:0]  load_dx,
  input  logic [1:0]  load_dy,
  output logic [63:0] asteroid_x,
  output logic [55:0] asteroid_y,
  output logic [7:0]  draw_asteroid,
  output logic        busy,
  output logic        update_done,
  output logic [3:0]  active_count,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);
  localparam int         CW    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      slot_q, slot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      act_q, act_d;
  logic [3:0]      active_count_q, active_count_d;
  logic [7:0]      x_q  [8];
  logic [7:0]      x_d  [8];
  logic [6:0]      y_q  [8];
  logic [6:0]      y_d  [8];
  logic [1:0]      dx_q [8];
  logic [1:0]      dx_d [8];
  logic [1:0]      dy_q [8];
  logic [1:0]      dy_d [8];

  // Velocities are stored normalised: 00 = 0, 01 = +1, 11 = -1.
  function automatic logic [7:0] step_x(input logic [7:0] x, input logic [1:0] d);
    if (d == 2'b01)      step_x = (x == X_MAX) ? 8'd0 : x + 8'd1;
    else if (d == 2'b11) step_x = (x == 8'd0) ? X_MAX : x - 8'd1;
    else                 step_x = x;
  endfunction

  function automatic logic [6:0] step_y(input logic [6:0] y, input logic [1:0] d);
    if (d == 2'b01)      step_y = (y == Y_MAX) ? 7'd0 : y + 7'd1;
    else if (d == 2'b11) step_y = (y == 7'd0) ? Y_MAX : y - 7'd1;
    else                 step_y = y;
  endfunction

  function automatic logic [1:0] norm_v(input logic [1:0] d);
    norm_v = (d == 2'b10) ? 2'b11 : d;
  endfunction

  // Spawn candidate decoded from the current LFSR value.
  logic [7:0] rx, sx;
  logic [6:0] ry, sy;
  logic [1:0] perp, sdx, sdy;
  logic       free_found;
  logic [2:0] free_idx;

  always_comb begin
    rx = lfsr_q[9:2];
    if (rx >= 8'(SCREEN_W)) rx = rx - 8'd96;
    ry = lfsr_q[8:2];
    if (ry >= 7'(SCREEN_H)) ry = ry - 7'd8;
    case (lfsr_q[11:10])
      2'b01:   perp = 2'b01;
      2'b10:   perp = 2'b11;
      default: perp = 2'b00;
    endcase
    sx  = rx;
    sy  = 7'd0;
    sdx = perp;
    sdy = 2'b01;
    case (lfsr_q[1:0])
      2'b00: begin sx = rx;    sy = 7'd0;  sdx = perp;  sdy = 2'b01; end
      2'b01: begin sx = rx;    sy = Y_MAX; sdx = perp;  sdy = 2'b11; end
      2'b10: begin sx = 8'd0;  sy = ry;    sdx = 2'b01; sdy = perp;  end
      default: begin sx = X_MAX; sy = ry;  sdx = 2'b11; sdy = perp;  end
    endcase
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  // kill_valid and load_valid are valid-only strobes with no ready: kill is
  // taken in any state, load only in IDLE (silently dropped otherwise).
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          x_d[load_index]   = (load_x > X_MAX) ? X_MAX : load_x;
          y_d[load_index]   = (load_y > Y_MAX) ? Y_MAX : load_y;
          dx_d[load_index]  = norm_v(load_dx);
          dy_d[load_index]  = norm_v(load_dy);
          act_d[load_index] = 1'b1;
        end
        if (frame_tick) begin
          state_d = UPDATE;
          slot_d  = 3'd0;
        end
      end
      UPDATE: begin
        if (act_q[slot_q]) begin
          x_d[slot_q] = step_x(x_q[slot_q], dx_q[slot_q]);
          y_d[slot_q] = step_y(y_q[slot_q], dy_q[slot_q]);
        end
        if (slot_q == 3'd7) state_d = SPAWN;
        else                slot_d  = slot_q + 3'd1;
      end
      SPAWN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (spawn_enable && free_found) begin
          x_d[free_idx]   = sx;
          y_d[free_idx]   = sy;
          dx_d[free_idx]  = sdx;
          dy_d[free_idx]  = sdy;
          act_d[free_idx] = 1'b1;
          cnt_d           = CW'(SPAWN_PERIOD - 1);
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Kill is applied last so it wins over a same-cycle load or spawn.
    if (kill_valid) act_d[kill_index] = 1'b0;
  end

  always_comb begin
    active_count_d = 4'd0;
    for (int i = 0; i < 8; i++) active_count_d = active_count_d + 4'(act_q[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      slot_q         <= 3'd0;
      cnt_q          <= '0;
      lfsr_q         <= LFSR_SEED;
      act_q          <= 8'd0;
      active_count_q <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        x_q[i]  <= 8'd0;
        y_q[i]  <= 7'd0;
        dx_q[i] <= 2'd0;
        dy_q[i] <= 2'd0;
      end
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      lfsr_q         <= lfsr_d;
      act_q          <= act_d;
      active_count_q <= active_count_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
    end
  end

  always_comb begin
    asteroid_x = '0;
    asteroid_y = '0;
    for (int i = 0; i < 8; i++) begin
      asteroid_x[8*i +: 8] = x_q[i];
      asteroid_y[7*i +: 7] = y_q[i];
    end
  end

  assign draw_asteroid = act_q;
  assign busy          = (state_q != IDLE);
  assign update_done   = (state_q == DONE);
  assign active_count  = active_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_asteroid_field.sv
// Self-checking bench for asteroid_field: directed load/step vectors plus
// multi-cycle sequences for spawning, kills and ignored frame ticks.
module tb_asteroid_field;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        spawn_enable = 1'b0;
  logic        kill_valid = 1'b0;
  logic [2:0]  kill_index = 3'd0;
  logic        load_valid = 1'b0;
  logic [2:0]  load_index = 3'd0;
  logic [7:0]  load_x = 8'd0;
  logic [6:0]  load_y = 7'd0;
  logic [1:0]  load_dx = 2'd0;
  logic [1:0]  load_dy = 2'd0;
  logic [63:0] asteroid_x;
  logic [55:0] asteroid_y;
  logic [7:0]  draw_asteroid;
  logic        busy;
  logic        update_done;
  logic [3:0]  active_count;
  logic [1:0]  dbg_state;

  asteroid_field dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .spawn_enable(spawn_enable), .kill_valid(kill_valid), .kill_index(kill_index),
    .load_valid(load_valid), .load_index(load_index), .load_x(load_x),
    .load_y(load_y), .load_dx(load_dx), .load_dy(load_dy),
    .asteroid_x(asteroid_x), .asteroid_y(asteroid_y),
    .draw_asteroid(draw_asteroid), .busy(busy), .update_done(update_done),
    .active_count(active_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] lfsr_m;
  logic [7:0]  mx  [8];
  logic [6:0]  my  [8];
  logic [1:0]  mdx [8];
  logic [1:0]  mdy [8];
  logic [7:0]  mact;
  int          mcnt;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clock) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_next(lfsr_m);
  end

  function automatic logic [7:0] m_x(input logic [7:0] x, input logic [1:0] d);
    case (d)
      2'b01:   m_x = (x == 8'd159) ? 8'd0 : x + 8'd1;
      2'b11:   m_x = (x == 8'd0) ? 8'd159 : x - 8'd1;
      default: m_x = x;
    endcase
  endfunction

  function automatic logic [6:0] m_y(input logic [6:0] y, input logic [1:0] d);
    case (d)
      2'b01:   m_y = (y == 7'd119) ? 7'd0 : y + 7'd1;
      2'b11:   m_y = (y == 7'd0) ? 7'd119 : y - 7'd1;
      default: m_y = y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mact = 8'd0;
    mcnt = 0;
    for (int i = 0; i < 8; i++) begin
      mx[i] = 8'd0; my[i] = 7'd0; mdx[i] = 2'd0; mdy[i] = 2'd0;
    end
  endtask

  task automatic model_load(input logic [2:0] idx, input logic [7:0] x, input logic [6:0] y,
                            input logic [1:0] dx, input logic [1:0] dy);
    mx[idx]   = (x > 8'd159) ? 8'd159 : x;
    my[idx]   = (y > 7'd119) ? 7'd119 : y;
    mdx[idx]  = (dx == 2'b10) ? 2'b11 : dx;
    mdy[idx]  = (dy == 2'b10) ? 2'b11 : dy;
    mact[idx] = 1'b1;
  endtask

  task automatic do_load(input logic [2:0] idx, input logic [7:0] x, input logic [6:0] y,
                         input logic [1:0] dx, input logic [1:0] dy);
    load_valid = 1'b1; load_index = idx; load_x = x; load_y = y; load_dx = dx; load_dy = dy;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    model_load(idx, x, y, dx, dy);
  endtask

  task automatic do_kill(input logic [2:0] idx);
    kill_valid = 1'b1; kill_index = idx;
    @(posedge clock);
    #1;
    kill_valid = 1'b0;
    mact[idx] = 1'b0;
  endtask

  task automatic model_spawn(input logic [15:0] l);
    logic [7:0] rx;
    logic [6:0] ry;
    logic [1:0] perp;
    int k;
    if (mcnt != 0) begin
      mcnt--;
    end else if (spawn_enable && mact != 8'hFF) begin
      k = 0;
      while (mact[k]) k++;
      rx = l[9:2];
      if (rx >= 8'd160) rx = rx - 8'd96;
      ry = l[8:2];
      if (ry >= 7'd120) ry = ry - 7'd8;
      perp = (l[11:10] == 2'b01) ? 2'b01 : (l[11:10] == 2'b10) ? 2'b11 : 2'b00;
      case (l[1:0])
        2'b00: begin mx[k] = rx;     my[k] = 7'd0;   mdx[k] = perp;  mdy[k] = 2'b01; end
        2'b01: begin mx[k] = rx;     my[k] = 7'd119; mdx[k] = perp;  mdy[k] = 2'b11; end
        2'b10: begin mx[k] = 8'd0;   my[k] = ry;     mdx[k] = 2'b01; mdy[k] = perp;  end
        default: begin mx[k] = 8'd159; my[k] = ry;   mdx[k] = 2'b11; mdy[k] = perp;  end
      endcase
      mact[k] = 1'b1;
      mcnt = 7;
    end
  endtask

  // Pulse frame_tick in cycle T, run to T+15 checking busy/update_done timing,
  // optionally kill at offset kill_off and re-pulse frame_tick at extra_off.
  task automatic do_tick(input int kill_off, input logic [2:0] kidx, input int extra_off);
    int busy_n, done_n, done_at;
    logic [15:0] l;
    busy_n = 0; done_n = 0; done_at = -1;
    l = lfsr_m;
    for (int i = 0; i < 9; i++) l = lfsr_next(l);
    for (int c = 0; c < 15; c++) begin
      frame_tick = (c == 0) || (c == extra_off);
      kill_valid = (c == kill_off);
      kill_index = kidx;
      if (c == 1) load_valid = 1'b0;
      if (busy) busy_n++;
      if (update_done) begin done_n++; done_at = c; end
      if (c == 0) chk("busy_before_tick", 64'(busy), 64'd0);
      @(posedge clock);
      #1;
    end
    frame_tick = 1'b0;
    kill_valid = 1'b0;
    chk("busy_cycles", 64'(busy_n), 64'd10);
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("done_offset", 64'(done_at), 64'd10);
    for (int i = 0; i < 8; i++) begin
      if (mact[i]) begin mx[i] = m_x(mx[i], mdx[i]); my[i] = m_y(my[i], mdy[i]); end
    end
    if (kill_off >= 1 && kill_off <= 8) mact[kidx] = 1'b0;
    model_spawn(l);
    if (kill_off == 9) mact[kidx] = 1'b0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) begin
      if (mact[i]) begin
        chk($sformatf("slot%0d_x", i), 64'(asteroid_x[8*i +: 8]), 64'(mx[i]));
        chk($sformatf("slot%0d_y", i), 64'(asteroid_y[7*i +: 7]), 64'(my[i]));
      end
    end
    chk("draw_mask", 64'(draw_asteroid), 64'(mact));
    chk("active_count", 64'(active_count), 64'($countones(mact)));
  endtask

  typedef struct {
    logic [2:0] idx;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [1:0] ldx;
    logic [1:0] ldy;
    logic [7:0] ex;
    logic [6:0] ey;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'd1, 8'd159, 7'd60,  2'b01, 2'b00, 8'd0,   7'd60};
    vecs[1] = '{3'd0, 8'd0,   7'd0,   2'b11, 2'b11, 8'd159, 7'd119};
    vecs[2] = '{3'd2, 8'd200, 7'd100, 2'b00, 2'b01, 8'd159, 7'd101};
    vecs[3] = '{3'd3, 8'd10,  7'd127, 2'b01, 2'b10, 8'd11,  7'd118};
    vecs[4] = '{3'd7, 8'd80,  7'd119, 2'b00, 2'b01, 8'd80,  7'd0};
    vecs[5] = '{3'd4, 8'd0,   7'd5,   2'b01, 2'b11, 8'd1,   7'd4};
    vecs[6] = '{3'd5, 8'd158, 7'd0,   2'b01, 2'b10, 8'd159, 7'd119};
    vecs[7] = '{3'd6, 8'd255, 7'd0,   2'b00, 2'b00, 8'd159, 7'd0};

    // Reset state
    do_reset();
    chk("rst_x", asteroid_x, 64'd0);
    chk("rst_y", 64'(asteroid_y), 64'd0);
    chk("rst_draw", 64'(draw_asteroid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(update_done), 64'd0);
    chk("rst_count", 64'(active_count), 64'd0);

    // Three empty frames with spawning disabled
    spawn_enable = 1'b0;
    for (int t = 0; t < 3; t++) begin
      do_tick(-1, 3'd0, -1);
      chk("empty_x", asteroid_x, 64'd0);
      chk("empty_y", 64'(asteroid_y), 64'd0);
      chk("empty_draw", 64'(draw_asteroid), 64'd0);
    end

    // Single-slot load-and-step vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      do_load(vecs[v].idx, vecs[v].lx, vecs[v].ly, vecs[v].ldx, vecs[v].ldy);
      do_tick(-1, 3'd0, -1);
      chk($sformatf("vec%0d_xbus", v), asteroid_x, 64'(vecs[v].ex) << (8 * vecs[v].idx));
      chk($sformatf("vec%0d_ybus", v), 64'(asteroid_y), 64'(vecs[v].ey) << (7 * vecs[v].idx));
      chk($sformatf("vec%0d_draw", v), 64'(draw_asteroid), 64'd1 << vecs[v].idx);
      check_all();
    end

    // Two consecutive frames with wrap at the origin
    do_reset();
    do_load(3'd0, 8'd0, 7'd0, 2'b11, 2'b11);
    do_tick(-1, 3'd0, -1);
    chk("wrap1_x", 64'(asteroid_x[7:0]), 64'd159);
    chk("wrap1_y", 64'(asteroid_y[6:0]), 64'd119);
    do_tick(-1, 3'd0, -1);
    chk("wrap2_x", 64'(asteroid_x[7:0]), 64'd158);
    chk("wrap2_y", 64'(asteroid_y[6:0]), 64'd118);

    // Load in the same cycle as frame_tick: applied, then stepped
    do_reset();
    load_valid = 1'b1; load_index = 3'd4; load_x = 8'd10; load_y = 7'd10;
    load_dx = 2'b01; load_dy = 2'b01;
    model_load(3'd4, 8'd10, 7'd10, 2'b01, 2'b01);
    do_tick(-1, 3'd0, -1);
    chk("loadtick_x", 64'(asteroid_x[39:32]), 64'd11);
    chk("loadtick_y", 64'(asteroid_y[34:28]), 64'd11);

    // Periodic spawning over 17 frames
    do_reset();
    spawn_enable = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      do_tick(-1, 3'd0, -1);
      check_all();
    end
    chk("spawn_draw", 64'(draw_asteroid), 64'h07);
    chk("spawn_count", 64'(active_count), 64'd3);

    // Full field: spawn due but no free slot, then a kill frees slot 5
    do_reset();
    spawn_enable = 1'b1;
    for (int i = 0; i < 8; i++) do_load(3'(i), 8'(i * 10), 7'(i * 5), 2'b01, 2'b00);
    do_tick(-1, 3'd0, -1);
    check_all();
    chk("full_draw", 64'(draw_asteroid), 64'hFF);
    do_kill(3'd5);
    @(posedge clock);
    #1;
    chk("kill5_draw", 64'(draw_asteroid), 64'hDF);
    do_tick(-1, 3'd0, -1);
    check_all();
    chk("respawn5_draw", 64'(draw_asteroid), 64'hFF);

    // Kill in the UPDATE cycle of slot 3
    do_reset();
    spawn_enable = 1'b0;
    do_load(3'd0, 8'd20, 7'd20, 2'b01, 2'b00);
    do_load(3'd3, 8'd50, 7'd50, 2'b01, 2'b01);
    do_tick(4, 3'd3, -1);
    chk("killupd_draw", 64'(draw_asteroid), 64'h01);
    check_all();

    // Kill in the SPAWN cycle that targets slot 3
    do_reset();
    spawn_enable = 1'b1;
    for (int i = 0; i < 3; i++) do_load(3'(i), 8'(30 + i), 7'(40 + i), 2'b00, 2'b01);
    do_tick(9, 3'd3, -1);
    chk("killspawn_draw", 64'(draw_asteroid), 64'h07);
    check_all();

    // frame_tick while busy (UPDATE and DONE) is ignored
    do_reset();
    spawn_enable = 1'b0;
    do_load(3'd2, 8'd100, 7'd100, 2'b11, 2'b00);
    do_tick(-1, 3'd0, 3);
    check_all();
    do_tick(-1, 3'd0, 10);
    check_all();
    chk("ignored_x", 64'(asteroid_x[23:16]), 64'd98);
    chk("idle_after", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
